btn_event_classifier: RTL and testbench

- Consumes the single-bit debounced button level from the debounce stage, one instance per button.
- Classifies each press as a short press, double click, or long press, and generates auto-repeat ticks while a long press is held.
- All outputs are single-cycle pulses, except oHeld, and are consumed directly by the mode/control FSMs.
- Pure synchronous logic; the input is already synchronised and glitch-free.

---
 rtl/btn_event_classifier.sv | 176 +++++++++++++++++
 tb/tb_btn_event_classifier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/btn_event_classifier.sv
// Classifies a debounced button level into press/release, short press, double click,
// long press and auto-repeat pulses, plus a held level. One instance per button.
module btn_event_classifier #(
   parameter int P_CLK_HZ    = 100000000,
   parameter int P_LONG_MS   = 1000,
   parameter int P_REPEAT_MS = 200,
   parameter int P_DCLICK_MS = 300
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iBtn,
   output logic       oPress,
   output logic       oRelease,
   output logic       oShortPress,
   output logic       oDoubleClick,
   output logic       oLongPress,
   output logic       oRepeat,
   output logic       oHeld,
   output logic [2:0] oDbgState
);

   localparam int LP_LONG_CNT = (P_CLK_HZ / 1000) * P_LONG_MS;
   localparam int LP_REP_CNT  = (P_CLK_HZ / 1000) * P_REPEAT_MS;
   localparam int LP_DC_CNT   = (P_CLK_HZ / 1000) * P_DCLICK_MS;
   localparam int LP_MAX_A    = (LP_LONG_CNT > LP_REP_CNT) ? LP_LONG_CNT : LP_REP_CNT;
   localparam int LP_MAX_CNT  = (LP_MAX_A > LP_DC_CNT) ? LP_MAX_A : LP_DC_CNT;
   localparam int CNT_W       = $clog2(LP_MAX_CNT);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t LONG_LAST = cnt_t'(LP_LONG_CNT - 1);
   localparam cnt_t REP_LAST  = cnt_t'(LP_REP_CNT - 1);
   localparam cnt_t DC_LAST   = cnt_t'(LP_DC_CNT - 1);
   localparam cnt_t CNT_ONE   = cnt_t'(1);

   generate
      if (LP_LONG_CNT < 2 || LP_REP_CNT < 2 || LP_DC_CNT < 2) begin : g_bad_params
         $error("btn_event_classifier: every derived count must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRESSED   = 3'd1,
      ST_LONG_HELD = 3'd2,
      ST_WAIT_2ND  = 3'd3,
      ST_SECOND    = 3'd4
   } state_t;

   state_t state_q, state_d;
   cnt_t   cnt_q, cnt_d;
   logic   btn_prev_q, btn_prev_d;
   logic   press_q, press_d;
   logic   release_q, release_d;
   logic   short_q, short_d;
   logic   dclick_q, dclick_d;
   logic   long_q, long_d;
   logic   repeat_q, repeat_d;
   logic   held_q, held_d;
   logic   rise, fall;

   always_comb begin
      rise       = iBtn & ~btn_prev_q;
      fall       = ~iBtn & btn_prev_q;
      btn_prev_d = iBtn;
      state_d    = state_q;
      cnt_d      = cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      short_d    = 1'b0;
      dclick_d   = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rise) begin
               state_d = ST_PRESSED;
               press_d = 1'b1;
            end
         end
         ST_PRESSED: begin
            // A release landing on the long threshold still counts as a short press.
            if (fall) begin
               state_d   = ST_WAIT_2ND;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (iBtn && cnt_q == LONG_LAST) begin
               state_d = ST_LONG_HELD;
               cnt_d   = '0;
               long_d  = 1'b1;
            end else if (iBtn) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_LONG_HELD: begin
            if (fall) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (cnt_q == REP_LAST) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_WAIT_2ND: begin
            // A second press on the very last window cycle still wins over expiry.
            if (rise) begin
               state_d  = ST_SECOND;
               cnt_d    = '0;
               press_d  = 1'b1;
               dclick_d = 1'b1;
            end else if (cnt_q == DC_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               short_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SECOND: begin
            cnt_d = '0;
            if (fall) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD) ||
               (state_d == ST_SECOND);
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         btn_prev_q <= 1'b1;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         short_q    <= 1'b0;
         dclick_q   <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
         held_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         btn_prev_q <= btn_prev_d;
         press_q    <= press_d;
         release_q  <= release_d;
         short_q    <= short_d;
         dclick_q   <= dclick_d;
         long_q     <= long_d;
         repeat_q   <= repeat_d;
         held_q     <= held_d;
      end
   end

   assign oPress       = press_q;
   assign oRelease     = release_q;
   assign oShortPress  = short_q;
   assign oDoubleClick = dclick_q;
   assign oLongPress   = long_q;
   assign oRepeat      = repeat_q;
   assign oHeld        = held_q;
   assign oDbgState    = state_q;

endmodule

// File: tb/tb_btn_event_classifier.sv
// Directed bench for btn_event_classifier with LONG=10, REP=4, DC=5 cycles.
// Each step drives iBtn, waits one clock edge, then checks every output.
module tb_btn_event_classifier;

   localparam logic [6:0] E_P = 7'b1000000;  // oPress
   localparam logic [6:0] E_R = 7'b0100000;  // oRelease
   localparam logic [6:0] E_S = 7'b0010000;  // oShortPress
   localparam logic [6:0] E_D = 7'b0001000;  // oDoubleClick
   localparam logic [6:0] E_L = 7'b0000100;  // oLongPress
   localparam logic [6:0] E_T = 7'b0000010;  // oRepeat
   localparam logic [6:0] E_H = 7'b0000001;  // oHeld
   localparam logic [6:0] E_0 = 7'b0000000;

   localparam logic [2:0] S_IDLE = 3'd0;

   logic       clk;
   logic       rst;
   logic       btn;
   logic       o_press, o_release, o_short, o_dclick, o_long, o_repeat, o_held;
   logic [2:0] o_state;

   int total = 0;
   int bad   = 0;

   btn_event_classifier #(
      .P_CLK_HZ    (1000),
      .P_LONG_MS   (10),
      .P_REPEAT_MS (4),
      .P_DCLICK_MS (5)
   ) dut (
      .iClk         (clk),
      .iRst         (rst),
      .iBtn         (btn),
      .oPress       (o_press),
      .oRelease     (o_release),
      .oShortPress  (o_short),
      .oDoubleClick (o_dclick),
      .oLongPress   (o_long),
      .oRepeat      (o_repeat),
      .oHeld        (o_held),
      .oDbgState    (o_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc(input logic b, input logic [6:0] exp, input string tag);
      logic [6:0] obs;
      btn = b;
      @(posedge clk);
      #1;
      obs = {o_press, o_release, o_short, o_dclick, o_long, o_repeat, o_held};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: outputs observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(1'b0, E_0, tag);
   endtask

   task automatic chk_state(input logic [2:0] exp, input string tag);
      total++;
      assert (o_state === exp) else begin
         bad++;
         $error("FAIL %s: state observed=%0d expected=%0d", tag, o_state, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b1;

      // Reset with the button held: nothing may fire until it is released and pressed.
      cyc(1'b1, E_0, "reset_a");
      cyc(1'b1, E_0, "reset_b");
      chk_state(S_IDLE, "reset_state");
      rst = 1'b0;
      cyc(1'b1, E_0, "held_thru_reset_a");
      cyc(1'b1, E_0, "held_thru_reset_b");
      cyc(1'b1, E_0, "held_thru_reset_c");
      cyc(1'b0, E_0, "held_thru_reset_release");

      // Short press: 3 cycles high, then short press 5 cycles after release.
      cyc(1'b1, E_P | E_H, "short_press_edge");
      cyc(1'b1, E_H, "short_hold_1");
      cyc(1'b1, E_H, "short_hold_2");
      cyc(1'b0, E_R, "short_release");
      idle_cycles(4, "short_window");
      cyc(1'b0, E_S, "short_confirm");
      cyc(1'b0, E_0, "short_after");
      chk_state(S_IDLE, "short_idle");

      // Double click: 2 high, 2 low, 2 high, low.
      cyc(1'b1, E_P | E_H, "dc_press1");
      cyc(1'b1, E_H, "dc_hold1");
      cyc(1'b0, E_R, "dc_release1");
      cyc(1'b0, E_0, "dc_gap");
      cyc(1'b1, E_P | E_D | E_H, "dc_press2");
      cyc(1'b1, E_H, "dc_hold2");
      cyc(1'b0, E_R, "dc_release2");
      idle_cycles(7, "dc_no_short");
      chk_state(S_IDLE, "dc_idle");

      // Long hold of 25 cycles: long at +10, repeats at +14, +18, +22.
      cyc(1'b1, E_P | E_H, "long_press_edge");
      for (int k = 1; k <= 24; k++) begin
         logic [6:0] e;
         e = E_H;
         if (k == 10) e = e | E_L;
         if (k > 10 && ((k - 10) % 4) == 0) e = e | E_T;
         cyc(1'b1, e, "long_hold");
      end
      cyc(1'b0, E_R, "long_release");
      idle_cycles(7, "long_no_short");
      chk_state(S_IDLE, "long_idle");

      // Release on the same edge as a repeat tick: the tick is dropped.
      cyc(1'b1, E_P | E_H, "rep_fall_press");
      for (int k = 1; k <= 13; k++) cyc(1'b1, (k == 10) ? (E_L | E_H) : E_H, "rep_fall_hold");
      cyc(1'b0, E_R, "rep_fall_release");
      idle_cycles(6, "rep_fall_no_short");

      // Release exactly on hold cycle 10: short path, no long press.
      cyc(1'b1, E_P | E_H, "edge10_press");
      for (int k = 1; k <= 9; k++) cyc(1'b1, E_H, "edge10_hold");
      cyc(1'b0, E_R, "edge10_release");
      idle_cycles(4, "edge10_window");
      cyc(1'b0, E_S, "edge10_short");
      cyc(1'b0, E_0, "edge10_after");

      // Second press on the last window cycle still counts as a double click;
      // the second press is held past the long threshold without a long press.
      cyc(1'b1, E_P | E_H, "dcx_press1");
      cyc(1'b0, E_R, "dcx_release1");
      idle_cycles(4, "dcx_window");
      cyc(1'b1, E_P | E_D | E_H, "dcx_press2");
      for (int k = 1; k <= 12; k++) cyc(1'b1, E_H, "dcx_second_hold");
      cyc(1'b0, E_R, "dcx_release2");
      idle_cycles(7, "dcx_no_short");
      chk_state(S_IDLE, "dcx_idle");

      // Reset while waiting for a second press discards the pending short press.
      cyc(1'b1, E_P | E_H, "rstw_press");
      cyc(1'b0, E_R, "rstw_release");
      idle_cycles(2, "rstw_wait");
      rst = 1'b1;
      cyc(1'b0, E_0, "rstw_reset");
      chk_state(S_IDLE, "rstw_state");
      rst = 1'b0;
      idle_cycles(7, "rstw_no_short");
      cyc(1'b1, E_P | E_H, "rstw_new_press");
      cyc(1'b0, E_R, "rstw_new_release");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
